// File: rtl/game_pkg.sv
// Shared game definitions: scene encodings, coordinate width, slot/retire
// enums and the lane-select LFSR.
package game_pkg;

    localparam int unsigned COORD_W   = 9;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        SCENE_TITLE = 2'd0,
        SCENE_PLAY  = 2'd1,
        SCENE_OVER  = 2'd2,
        SCENE_RSVD  = 2'd3
    } scene_e;

    typedef enum logic {
        SLOT_FREE,
        SLOT_ACTIVE
    } slot_state_e;

    typedef enum logic [1:0] {
        RET_NONE,
        RET_HIT,
        RET_KILL,
        RET_AVOID
    } retire_e;

    // Fibonacci LFSR, taps 16,14,13,11, shifting towards bit 0
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

endpackage

// File: rtl/enemy_slot.sv
// One enemy slot: FREE/ACTIVE state, position, and retirement decision
// (colision beats bullet beats leaving the playfield).
module enemy_slot
    import game_pkg::*;
#(
    parameter int unsigned SCREEN_H = 238
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    play,
    input  logic    spawn,
    input  coord_t  spawn_x,
    input  logic    step,
    input  logic    colision,
    input  logic    bullet,
    output coord_t  x,
    output coord_t  y,
    output logic    active,
    output retire_e retire
);

    localparam coord_t Y_LIMIT = COORD_W'(SCREEN_H);

    slot_state_e state_q, state_d;
    coord_t      x_q, x_d, y_q, y_d;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        retire  = RET_NONE;

        if (play && state_q == SLOT_ACTIVE) begin
            if (colision)           retire = RET_HIT;
            else if (bullet)        retire = RET_KILL;
            else if (y_q >= Y_LIMIT) retire = RET_AVOID;
        end

        // Retirement is evaluated before movement, so Y never steps past the limit
        if (!play || retire != RET_NONE) begin
            state_d = SLOT_FREE;
            x_d     = '0;
            y_d     = '0;
        end else if (state_q == SLOT_ACTIVE) begin
            if (step) y_d = y_q + 1'b1;
        end else if (spawn) begin
            state_d = SLOT_ACTIVE;
            x_d     = spawn_x;
            y_d     = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SLOT_FREE;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign active = (state_q == SLOT_ACTIVE);

endmodule

// File: rtl/enemy_pool.sv
// Pool of falling enemies: spawn timer, lane LFSR and move divider shared
// across N_ENEMY slots; registered retirement event pulses and count.
module enemy_pool
    import game_pkg::*;
#(
    parameter int unsigned N_ENEMY    = 4,
    parameter int unsigned SCREEN_H   = 238,
    parameter int unsigned LANE_X0    = 64,
    parameter int unsigned LANE_PITCH = 48,
    parameter int unsigned N_LANES    = 4,
    parameter int unsigned SPAWN_GAP  = 40
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clk_en,
    input  logic [1:0]             scene,
    input  logic [4:0]             level,
    input  logic [N_ENEMY-1:0]     colision_vec,
    input  logic [N_ENEMY-1:0]     bullet_vec,
    output logic [9*N_ENEMY-1:0]   X_vec,
    output logic [9*N_ENEMY-1:0]   Y_vec,
    output logic [N_ENEMY-1:0]     active,
    output logic                   avoided,
    output logic                   hit,
    output logic                   killed,
    output logic [3:0]             event_cnt
);

    localparam logic [15:0] GAP = 16'(SPAWN_GAP);

    logic [15:0]        lfsr_q, lfsr_d;
    logic [15:0]        timer_q, timer_d;
    logic [3:0]         div_q, div_d;
    logic               avoided_q, avoided_d, hit_q, hit_d, killed_q, killed_d;
    logic [3:0]         cnt_q, cnt_d;

    logic               play, step, found;
    logic [2:0]         lvl_hi;
    logic [3:0]         div_limit;
    logic [N_ENEMY-1:0] spawn_vec, pick_vec;
    int unsigned        lane;
    coord_t             spawn_x;
    retire_e            retire [N_ENEMY];

    assign play = (scene_e'(scene) == SCENE_PLAY);

    always_comb begin
        lfsr_d    = clk_en ? lfsr_next(lfsr_q) : lfsr_q;
        lane      = 32'(lfsr_q) % N_LANES;
        spawn_x   = COORD_W'(LANE_X0 + lane * LANE_PITCH);
        lvl_hi    = 3'(level >> 2);
        div_limit = 4'd8 - {1'b0, lvl_hi};
        if (div_limit == 4'd0) div_limit = 4'd1;

        pick_vec = '0;
        found    = 1'b0;
        for (int unsigned i = 0; i < N_ENEMY; i++) begin
            if (!active[i] && !found) begin
                pick_vec[i] = 1'b1;
                found       = 1'b1;
            end
        end

        div_d     = div_q;
        timer_d   = timer_q;
        step      = 1'b0;
        spawn_vec = '0;
        if (!play) begin
            div_d   = '0;
            timer_d = GAP;
        end else if (clk_en) begin
            if (div_q + 4'd1 >= div_limit) begin
                div_d = '0;
                step  = 1'b1;
            end else begin
                div_d = div_q + 4'd1;
            end
            // Timer parks at zero while the pool is full; spawn fires on the first tick a slot is free
            if (timer_q <= 16'd1) begin
                if (found) begin
                    spawn_vec = pick_vec;
                    timer_d   = GAP;
                end else begin
                    timer_d = '0;
                end
            end else begin
                timer_d = timer_q - 16'd1;
            end
        end

        avoided_d = 1'b0;
        hit_d     = 1'b0;
        killed_d  = 1'b0;
        cnt_d     = '0;
        for (int unsigned i = 0; i < N_ENEMY; i++) begin
            if (retire[i] == RET_HIT)   hit_d     = 1'b1;
            if (retire[i] == RET_KILL)  killed_d  = 1'b1;
            if (retire[i] == RET_AVOID) avoided_d = 1'b1;
            if (retire[i] != RET_NONE)  cnt_d     = cnt_d + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q    <= LFSR_SEED;
            timer_q   <= GAP;
            div_q     <= '0;
            avoided_q <= 1'b0;
            hit_q     <= 1'b0;
            killed_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            lfsr_q    <= lfsr_d;
            timer_q   <= timer_d;
            div_q     <= div_d;
            avoided_q <= avoided_d;
            hit_q     <= hit_d;
            killed_q  <= killed_d;
            cnt_q     <= cnt_d;
        end
    end

    for (genvar g = 0; g < N_ENEMY; g++) begin : g_slot
        coord_t sx, sy;
        enemy_slot #(.SCREEN_H(SCREEN_H)) u_slot (
            .clk      (clk),
            .rst      (rst),
            .play     (play),
            .spawn    (spawn_vec[g]),
            .spawn_x  (spawn_x),
            .step     (step),
            .colision (colision_vec[g]),
            .bullet   (bullet_vec[g]),
            .x        (sx),
            .y        (sy),
            .active   (active[g]),
            .retire   (retire[g])
        );
        assign X_vec[COORD_W*g +: COORD_W] = sx;
        assign Y_vec[COORD_W*g +: COORD_W] = sy;
    end

    assign avoided   = avoided_q;
    assign hit       = hit_q;
    assign killed    = killed_q;
    assign event_cnt = cnt_q;

endmodule

// File: tb/tb_enemy_pool.sv
// Directed bench for enemy_pool: expected event pulses are queued by the
// stimulus and popped by a monitor whenever the pool reports an event.
module tb_enemy_pool;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clk_en = 1'b0;
    logic [1:0]  scene = 2'd0;
    logic [4:0]  level = 5'd0;
    logic [3:0]  colision_vec = '0;
    logic [3:0]  bullet_vec = '0;
    logic [35:0] X_vec, Y_vec;
    logic [3:0]  active;
    logic        avoided, hit, killed;
    logic [3:0]  event_cnt;

    typedef struct packed {
        logic       a;
        logic       h;
        logic       k;
        logic [3:0] cnt;
    } ev_t;

    ev_t exp_q[$];
    ev_t exp_e;
    int  tests = 0;
    int  fails = 0;

    enemy_pool #(
        .N_ENEMY(4), .SCREEN_H(238), .LANE_X0(64), .LANE_PITCH(48),
        .N_LANES(4), .SPAWN_GAP(40)
    ) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .scene(scene), .level(level),
        .colision_vec(colision_vec), .bullet_vec(bullet_vec),
        .X_vec(X_vec), .Y_vec(Y_vec), .active(active),
        .avoided(avoided), .hit(hit), .killed(killed), .event_cnt(event_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (avoided || hit || killed || event_cnt != 4'd0) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_event: got a=%0b h=%0b k=%0b cnt=%0d, expected no event",
                         avoided, hit, killed, event_cnt);
            end else begin
                exp_e = exp_q.pop_front();
                if ({avoided, hit, killed, event_cnt} !== exp_e) begin
                    fails++;
                    $display("FAIL event: got a=%0b h=%0b k=%0b cnt=%0d, expected a=%0b h=%0b k=%0b cnt=%0d",
                             avoided, hit, killed, event_cnt, exp_e.a, exp_e.h, exp_e.k, exp_e.cnt);
                end
            end
        end
    end

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] xs(input int i);
        return X_vec[9*i +: 9];
    endfunction

    function automatic logic [8:0] ys(input int i);
        return Y_vec[9*i +: 9];
    endfunction

    task automatic check_lane(input string name, input logic [8:0] x);
        tests++;
        if (!(x == 9'd64 || x == 9'd112 || x == 9'd160 || x == 9'd208)) begin
            fails++;
            $display("FAIL %s: got X=%0d expected one of 64/112/160/208", name, x);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            clk_en = 1'b1;
            @(negedge clk);
            clk_en = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic overlap(input logic [3:0] c, input logic [3:0] b, input ev_t e);
        if (e.cnt != 4'd0) exp_q.push_back(e);
        colision_vec = c;
        bullet_vec   = b;
        @(negedge clk);
        colision_vec = '0;
        bullet_vec   = '0;
    endtask

    initial begin
        #1 rst = 1'b1;
        scene = 2'd1;
        repeat (2) @(negedge clk);
        check("reset_active", active, 0);
        check("reset_x", X_vec, 0);
        check("reset_y", Y_vec, 0);
        check("reset_pulses", {avoided, hit, killed, event_cnt}, 0);
        rst = 1'b0;

        // level 0: spawn on tick 40, then further spawns every 40 ticks
        tick(39);
        check("no_spawn_tick39", active, 0);
        tick(1);
        check("spawn_tick40", active, 4'b0001);
        check("spawn_y0", ys(0), 0);
        check_lane("spawn_x0", xs(0));

        tick(960);
        check("pool_full_no_spawn", active, 4'b1111);
        overlap(4'b0000, 4'b0100, '{a:1'b0, h:1'b0, k:1'b1, cnt:4'd1});
        check("kill_slot2", active, 4'b1011);
        tick(1);
        check("respawn_slot2", active, 4'b1111);
        check("respawn_y2", ys(2), 0);
        check_lane("respawn_x2", xs(2));

        tick(942);
        check("slot0_y237", ys(0), 237);
        exp_q.push_back('{a:1'b1, h:1'b0, k:1'b0, cnt:4'd1});
        tick(1);
        check("avoid_clears_slot0", active, 4'b1110);
        check("free_x0", xs(0), 0);
        check("free_y0", ys(0), 0);
        tick(1);
        check("held_timer_spawn", active, 4'b1111);
        check("held_spawn_y0", ys(0), 0);

        // colision beats bullet on the same slot; free-slot overlaps ignored
        overlap(4'b0010, 4'b0010, '{a:1'b0, h:1'b1, k:1'b0, cnt:4'd1});
        check("colision_priority", active, 4'b1101);
        overlap(4'b0011, 4'b1000, '{a:1'b0, h:1'b1, k:1'b1, cnt:4'd2});
        check("multi_retire", active, 4'b0100);

        tick(80);
        check("three_active", active, 4'b0111);
        scene = 2'd2;
        @(negedge clk);
        check("gameover_flush", active, 0);
        check("gameover_x", X_vec, 0);
        check("gameover_y", Y_vec, 0);
        tick(1);
        scene = 2'd3;
        tick(1);
        check("reserved_scene", active, 0);

        // level 31: one Y step per tick
        level = 5'd31;
        scene = 2'd1;
        tick(39);
        check("l31_no_spawn", active, 0);
        tick(1);
        check("l31_spawn", active, 4'b0001);
        tick(5);
        check("l31_y5", ys(0), 5);
        tick(232);
        check("l31_y237", ys(0), 237);
        exp_q.push_back('{a:1'b1, h:1'b0, k:1'b0, cnt:4'd1});
        tick(1);
        check("l31_avoid", active, 4'b1110);

        // asynchronous reset between edges
        #2 rst = 1'b1;
        #1;
        check("async_rst_active", active, 0);
        check("async_rst_x", X_vec, 0);
        check("async_rst_y", Y_vec, 0);
        check("async_rst_cnt", event_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        tick(39);
        check("post_rst_no_spawn", active, 0);
        tick(1);
        check("post_rst_spawn", active, 4'b0001);
        check_lane("post_rst_x0", xs(0));

        check("events_drained", 36'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
